// File: rtl/sa_result_drainer.sv
// sa_result_drainer: captures a flat result matrix into one of two ping-pong
// buffers and streams it out one row per valid/ready handshake, oldest first.
module sa_result_drainer #(
  parameter int D_W  = 16,
  parameter int SA_R = 16,
  parameter int SA_C = 16
) (
  input  logic                        I_CLK,
  input  logic                        I_ASYN_RSTN,
  input  logic                        I_SYNC_RSTN,
  input  logic                        I_MAT_VLD,
  input  logic [SA_R*SA_C*D_W-1:0]    I_MAT,
  output logic                        O_MAT_RDY,
  output logic                        O_OVF,
  output logic                        O_ROW_VLD,
  input  logic                        I_ROW_RDY,
  output logic [SA_C*D_W-1:0]         O_ROW,
  output logic [$clog2(SA_R)-1:0]     O_ROW_IDX,
  output logic                        O_ROW_LAST,
  output logic                        O_MAT_DONE
);

  localparam int ROW_W = SA_C * D_W;
  localparam int MAT_W = SA_R * ROW_W;
  localparam int IDX_W = $clog2(SA_R);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(SA_R - 1);

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       full_reg, full_next;
  logic             wptr_reg, wptr_next;
  logic             rptr_reg, rptr_next;
  logic [IDX_W-1:0] row_cnt_reg, row_cnt_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;

  logic [MAT_W-1:0] mat_reg [2];
  logic [MAT_W-1:0] rd_mat;
  logic [ROW_W-1:0] row_sel [SA_R];

  logic capture;
  logic xfer;
  logic last_xfer;

  // Ready depends only on registered occupancy, never on the input handshakes.
  assign O_MAT_RDY = ~(full_reg[0] & full_reg[1]);
  assign capture   = I_MAT_VLD & O_MAT_RDY;
  assign xfer      = (state_reg == ST_DRAIN) & I_ROW_RDY;
  assign last_xfer = xfer & (row_cnt_reg == LAST_ROW);
  assign O_OVF      = ovf_reg;
  assign O_MAT_DONE = done_reg;

  // Slice the buffer currently being drained into its rows.
  assign rd_mat = mat_reg[rptr_reg];
  for (genvar gi = 0; gi < SA_R; gi++) begin : g_row
    assign row_sel[gi] = rd_mat[gi*ROW_W +: ROW_W];
  end

  // Buffer storage: data needs no reset, the full flags decide validity.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    localparam logic SLOT = 1'(gi);
    always_ff @(posedge I_CLK) begin
      if (capture && (wptr_reg == SLOT)) begin
        mat_reg[gi] <= I_MAT;
      end
    end
  end

  // Next-state and row outputs. The FSM stays in DRAIN whenever the buffer
  // at the next read pointer holds a matrix, so a waiting or simultaneously
  // captured matrix follows the previous one without a bubble.
  always_comb begin
    full_next    = full_reg;
    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    row_cnt_next = row_cnt_reg;
    state_next   = state_reg;
    done_next    = last_xfer;
    ovf_next     = I_MAT_VLD & ~O_MAT_RDY;
    O_ROW_VLD    = 1'b0;
    O_ROW        = '0;
    O_ROW_IDX    = '0;
    O_ROW_LAST   = 1'b0;

    if (xfer) begin
      if (last_xfer) begin
        full_next[rptr_reg] = 1'b0;
        rptr_next           = ~rptr_reg;
        row_cnt_next        = '0;
      end else begin
        row_cnt_next = row_cnt_reg + 1'b1;
      end
    end

    // A capture always targets the non-draining buffer, so it never
    // collides with the flag cleared above.
    if (capture) begin
      full_next[wptr_reg] = 1'b1;
      wptr_next           = ~wptr_reg;
    end

    case (state_reg)
      ST_IDLE:  if (full_next[rptr_next])  state_next = ST_DRAIN;
      ST_DRAIN: if (!full_next[rptr_next]) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (state_reg == ST_DRAIN) begin
      O_ROW_VLD  = 1'b1;
      O_ROW      = row_sel[row_cnt_reg];
      O_ROW_IDX  = row_cnt_reg;
      O_ROW_LAST = (row_cnt_reg == LAST_ROW);
    end
  end

  // State register with asynchronous and synchronous clears.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_reg   <= ST_IDLE;
      full_reg    <= '0;
      wptr_reg    <= 1'b0;
      rptr_reg    <= 1'b0;
      row_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      state_reg   <= ST_IDLE;
      full_reg    <= '0;
      wptr_reg    <= 1'b0;
      rptr_reg    <= 1'b0;
      row_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      full_reg    <= full_next;
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      row_cnt_reg <= row_cnt_next;
      ovf_reg     <= ovf_next;
      done_reg    <= done_next;
    end
  end

endmodule

// File: tb/tb_sa_result_drainer.sv
// Bench for sa_result_drainer (4x4, 16-bit) against a queue-based model.
module tb_sa_result_drainer;

  localparam int D_W   = 16;
  localparam int SA_R  = 4;
  localparam int SA_C  = 4;
  localparam int ROW_W = SA_C * D_W;
  localparam int MAT_W = SA_R * ROW_W;

  logic             clk;
  logic             asyn_rstn;
  logic             sync_rstn;
  logic             mat_vld;
  logic [MAT_W-1:0] mat;
  logic             mat_rdy;
  logic             ovf;
  logic             row_vld;
  logic             row_rdy;
  logic [ROW_W-1:0] row;
  logic [1:0]       row_idx;
  logic             row_last;
  logic             mat_done;

  int checks = 0;
  int errors = 0;

  // Model: FIFO of captured matrices (at most two) and the next row of the head.
  logic [MAT_W-1:0] mq[$];
  int               m_row;
  logic             m_done;
  logic             m_ovf;

  sa_result_drainer #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
    .I_CLK       (clk),
    .I_ASYN_RSTN (asyn_rstn),
    .I_SYNC_RSTN (sync_rstn),
    .I_MAT_VLD   (mat_vld),
    .I_MAT       (mat),
    .O_MAT_RDY   (mat_rdy),
    .O_OVF       (ovf),
    .O_ROW_VLD   (row_vld),
    .I_ROW_RDY   (row_rdy),
    .O_ROW       (row),
    .O_ROW_IDX   (row_idx),
    .O_ROW_LAST  (row_last),
    .O_MAT_DONE  (mat_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_row  = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_outs(input string tag);
    logic [MAT_W-1:0] head;
    logic [ROW_W-1:0] e_row;
    logic             e_vld;
    e_vld = (mq.size() > 0);
    e_row = '0;
    if (e_vld) begin
      head  = mq[0];
      e_row = head[m_row*ROW_W +: ROW_W];
    end
    chk({tag, "_rdy"},  64'(mat_rdy),  64'(mq.size() < 2));
    chk({tag, "_vld"},  64'(row_vld),  64'(e_vld));
    chk({tag, "_row"},  64'(row),      64'(e_row));
    chk({tag, "_idx"},  64'(row_idx),  e_vld ? 64'(m_row) : 64'd0);
    chk({tag, "_last"}, 64'(row_last), 64'(e_vld && m_row == SA_R - 1));
    chk({tag, "_done"}, 64'(mat_done), 64'(m_done));
    chk({tag, "_ovf"},  64'(ovf),      64'(m_ovf));
    $display("cyc %s vld=%0b idx=%0d row=%h rdy=%0b done=%0b ovf=%0b",
             tag, row_vld, row_idx, row, mat_rdy, mat_done, ovf);
  endtask

  // One clock: called at a negedge; checks, drives, advances the model, waits.
  task automatic cycle(input string tag, input logic vld, input logic [MAT_W-1:0] m,
                       input logic rdy, input logic srst);
    logic cap, xf, m_rdy, m_vld;
    check_outs(tag);
    mat_vld   = vld;
    mat       = m;
    row_rdy   = rdy;
    sync_rstn = ~srst;
    m_rdy = (mq.size() < 2);
    m_vld = (mq.size() > 0);
    cap   = vld && m_rdy;
    xf    = m_vld && rdy;
    if (srst) begin
      model_clear();
    end else begin
      m_done = xf && (m_row == SA_R - 1);
      m_ovf  = vld && !m_rdy;
      if (xf) begin
        if (m_row == SA_R - 1) begin
          void'(mq.pop_front());
          m_row = 0;
        end else begin
          m_row++;
        end
      end
      if (cap) mq.push_back(m);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [MAT_W-1:0] pattern_mat(input logic [7:0] tag);
    logic [MAT_W-1:0] r;
    for (int ri = 0; ri < SA_R; ri++)
      for (int ci = 0; ci < SA_C; ci++)
        r[(ri*SA_C+ci)*D_W +: D_W] = {tag, 8'(ri), 8'(ci)} >> 0 == 0 ? '0 :
                                     16'({tag[3:0], 4'(ri), 8'(ci)});
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] r;
    for (int k = 0; k < MAT_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [MAT_W-1:0] ma, mb, mc, mt1;
  logic [MAT_W-1:0] zero_mat;

  initial begin
    zero_mat  = '0;
    asyn_rstn = 1'b0;
    sync_rstn = 1'b1;
    mat_vld   = 1'b0;
    mat       = '0;
    row_rdy   = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    asyn_rstn = 1'b1;

    // Test 1: element (r,c) = 16'h0100*r + c, free-flowing sink.
    for (int ri = 0; ri < SA_R; ri++)
      for (int ci = 0; ci < SA_C; ci++)
        mt1[(ri*SA_C+ci)*D_W +: D_W] = 16'(16'h0100 * ri + ci);
    cycle("t1_rst", 1'b1, mt1, 1'b1, 1'b0);
    cycle("t1", 1'b0, zero_mat, 1'b1, 1'b0);
    cycle("t1", 1'b0, zero_mat, 1'b1, 1'b0);
    chk("t1_row2_const", 64'(row), 64'h0203_0202_0201_0200);
    repeat (4) cycle("t1", 1'b0, zero_mat, 1'b1, 1'b0);

    // Test 2: back-to-back captures, no gap between matrices.
    ma = rand_mat();
    mb = rand_mat();
    cycle("t2", 1'b1, ma, 1'b1, 1'b0);
    cycle("t2", 1'b1, mb, 1'b1, 1'b0);
    repeat (9) cycle("t2", 1'b0, zero_mat, 1'b1, 1'b0);

    // Test 3: backpressure pattern 1,0,0,1,...
    ma = rand_mat();
    cycle("t3", 1'b1, ma, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++)
      cycle("t3", 1'b0, zero_mat, (k % 3) == 0, 1'b0);

    // Test 4: overflow with a stalled sink.
    ma = rand_mat();
    mb = rand_mat();
    mc = rand_mat();
    cycle("t4", 1'b1, ma, 1'b0, 1'b0);
    cycle("t4", 1'b1, mb, 1'b0, 1'b0);
    cycle("t4", 1'b1, mc, 1'b0, 1'b0);
    cycle("t4", 1'b0, zero_mat, 1'b0, 1'b0);
    repeat (10) cycle("t4", 1'b0, zero_mat, 1'b1, 1'b0);

    // Test 5a: asynchronous reset after row 1 has transferred.
    ma = rand_mat();
    cycle("t5a", 1'b1, ma, 1'b1, 1'b0);
    cycle("t5a", 1'b0, zero_mat, 1'b1, 1'b0);
    cycle("t5a", 1'b0, zero_mat, 1'b1, 1'b0);
    mat_vld   = 1'b0;
    asyn_rstn = 1'b0;
    #1;
    model_clear();
    check_outs("t5a_arst");
    @(negedge clk);
    asyn_rstn = 1'b1;
    repeat (3) cycle("t5a", 1'b0, zero_mat, 1'b1, 1'b0);

    // Test 5b: synchronous clear after row 1 has transferred.
    ma = rand_mat();
    cycle("t5b", 1'b1, ma, 1'b1, 1'b0);
    cycle("t5b", 1'b0, zero_mat, 1'b1, 1'b0);
    cycle("t5b", 1'b0, zero_mat, 1'b1, 1'b0);
    cycle("t5b", 1'b0, zero_mat, 1'b1, 1'b1);
    repeat (3) cycle("t5b", 1'b0, zero_mat, 1'b1, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++)
      cycle("rnd", ($urandom_range(0, 99) < 35), rand_mat(),
            ($urandom_range(0, 99) < 65), ($urandom_range(0, 199) == 0));
    repeat (12) cycle("tail", 1'b0, zero_mat, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
